// File: rtl/flow_led_mode_ctrl.sv
// Two-LED flow sequencer: a debounced key steps a one-hot mode, a per-mode step timer
// advances a 2-bit pattern phase, and the LED pattern is decoded from mode and phase.
module flow_led_mode_ctrl #(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned PERIOD_1     = 5_000_000,
  parameter int unsigned PERIOD_2     = 10_000_000,
  parameter int unsigned PERIOD_3     = 2_500_000,
  parameter int unsigned PERIOD_4     = 1_250_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_1,
  input  logic       run_en,
  output logic [3:0] mode,
  output logic       key_press,
  output logic       step_tick,
  output logic [1:0] led
);

  localparam logic [CNT_W-1:0] DbcLast = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] Last1   = CNT_W'(PERIOD_1 - 1);
  localparam logic [CNT_W-1:0] Last2   = CNT_W'(PERIOD_2 - 1);
  localparam logic [CNT_W-1:0] Last3   = CNT_W'(PERIOD_3 - 1);
  localparam logic [CNT_W-1:0] Last4   = CNT_W'(PERIOD_4 - 1);

  typedef enum logic [3:0] {
    StM1 = 4'b0001,
    StM2 = 4'b0010,
    StM3 = 4'b0100,
    StM4 = 4'b1000
  } state_e;

  // Key synchronizer and debounce
  logic             key_meta_q, key_s_q;
  logic             kst_q, kst_d;
  logic             kst_dly_q;
  logic [CNT_W-1:0] dbc_q, dbc_d;
  logic             key_press_q, key_press_d;

  // Mode FSM and step timer
  state_e           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] tcnt_last;
  logic [1:0]       phase_q, phase_d;
  logic             tick;
  logic [1:0]       led_q, led_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
    end else begin
      key_meta_q <= key_1;
      key_s_q    <= key_meta_q;
    end
  end

  // The stable level only follows key_s after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    kst_d = kst_q;
    dbc_d = '0;
    if (key_s_q != kst_q) begin
      if (dbc_q == DbcLast) begin
        kst_d = key_s_q;
      end else begin
        dbc_d = dbc_q + CNT_W'(1);
      end
    end
  end

  // Press pulse follows the cycle in which the stable level fell.
  assign key_press_d = kst_dly_q & ~kst_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      kst_q       <= 1'b1;
      kst_dly_q   <= 1'b1;
      dbc_q       <= '0;
      key_press_q <= 1'b0;
    end else begin
      kst_q       <= kst_d;
      kst_dly_q   <= kst_q;
      dbc_q       <= dbc_d;
      key_press_q <= key_press_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StM1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (key_press_q) begin
      unique case (state_q)
        StM1:    state_d = StM2;
        StM2:    state_d = StM3;
        StM3:    state_d = StM4;
        StM4:    state_d = StM1;
        default: state_d = StM1;
      endcase
    end
  end

  always_comb begin
    mode      = state_q;
    tcnt_last = Last1;
    unique case (state_q)
      StM1:    tcnt_last = Last1;
      StM2:    tcnt_last = Last2;
      StM3:    tcnt_last = Last3;
      StM4:    tcnt_last = Last4;
      default: tcnt_last = Last1;
    endcase
  end

  // A mode change restarts the period and phase and suppresses a coincident tick.
  always_comb begin
    tick    = run_en && (tcnt_q == tcnt_last) && !key_press_q;
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if (key_press_q) begin
      tcnt_d  = '0;
      phase_d = '0;
    end else if (run_en) begin
      if (tick) begin
        tcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        tcnt_d = tcnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    led_d = 2'b01;
    unique case (state_q)
      StM1:    led_d = phase_q[0] ? 2'b10 : 2'b01;
      StM2:    led_d = phase_q[0] ? 2'b11 : 2'b00;
      StM3:    led_d = phase_q[0] ? 2'b00 : 2'b01;
      StM4:    led_d = phase_q;
      default: led_d = 2'b01;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tcnt_q  <= '0;
      phase_q <= '0;
      led_q   <= 2'b01;
    end else begin
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign key_press = key_press_q;
  assign step_tick = tick;
  assign led       = led_q;

endmodule

// File: tb/tb_flow_led_mode_ctrl.sv
// Self-checking bench for flow_led_mode_ctrl: vector table, directed corner sequences and
// randomized key/run_en stimulus compared against a countdown-based reference model.
module tb_flow_led_mode_ctrl;

  localparam int DEB = 4;
  localparam int P1  = 4;
  localparam int P2  = 6;
  localparam int P3  = 8;
  localparam int P4  = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       key_1     = 1'b1;
  logic       run_en    = 1'b1;
  logic [3:0] mode;
  logic       key_press;
  logic       step_tick;
  logic [1:0] led;

  flow_led_mode_ctrl #(
    .CNT_W       (8),
    .DEBOUNCE_CYC(DEB),
    .PERIOD_1    (P1),
    .PERIOD_2    (P2),
    .PERIOD_3    (P3),
    .PERIOD_4    (P4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_1    (key_1),
    .run_en   (run_en),
    .mode     (mode),
    .key_press(key_press),
    .step_tick(step_tick),
    .led      (led)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode index, pattern table, countdown to next tick.
  int per [4]      = '{P1, P2, P3, P4};
  int led_tab [16] = '{1, 2, 1, 2,  0, 3, 0, 3,  1, 0, 1, 0,  0, 1, 2, 3};
  int m_s1, m_s2, m_stable, m_run, m_fell, m_press, m_idx, m_phase, m_left, m_led;

  logic [3:0] s_mode;
  logic [1:0] s_led;
  logic       s_press, s_tick;

  typedef struct packed {
    logic       key;
    logic       run;
    logic [3:0] mode;
    logic [1:0] led;
    logic       press;
    logic       tick;
  } vec_t;
  vec_t vq[$];

  int first_press, first_tick, npress, nchg, last_chg, nbad_frz, lvl, len, n;
  logic [1:0] prev_led;
  logic [3:0] wrap_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] m4_seq [4]   = '{2'b10, 2'b11, 2'b00, 2'b01};

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_stable = 1; m_run = 0; m_fell = 0; m_press = 0;
    m_idx = 0; m_phase = 0; m_left = per[0]; m_led = 1;
  endtask

  task automatic model_update(input logic k, input logic r);
    int fell_now;
    m_led = led_tab[m_idx * 4 + m_phase];
    if (m_press != 0) begin
      m_idx   = (m_idx + 1) % 4;
      m_phase = 0;
      m_left  = per[m_idx];
    end else if (r) begin
      if (m_left == 1) begin
        m_phase = (m_phase + 1) % 4;
        m_left  = per[m_idx];
      end else begin
        m_left--;
      end
    end
    m_press  = m_fell;
    fell_now = 0;
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_s2;
        m_run    = 0;
        fell_now = (m_stable == 0) ? 1 : 0;
      end
    end else begin
      m_run = 0;
    end
    m_fell = fell_now;
    m_s2   = m_s1;
    m_s1   = int'(k);
  endtask

  // Called at a falling clock edge; returns at the next falling edge.
  task automatic step(input logic k, input logic r);
    key_1  = k;
    run_en = r;
    #1;
    s_mode  = mode;
    s_led   = led;
    s_press = key_press;
    s_tick  = step_tick;
    check("model_mode", int'(s_mode), 1 << m_idx);
    check("model_led", int'(s_led), m_led);
    check("model_press", int'(s_press), m_press);
    check("model_tick", int'(s_tick), (r && m_left == 1 && m_press == 0) ? 1 : 0);
    @(posedge sys_clk);
    model_update(k, r);
    @(negedge sys_clk);
  endtask

  task automatic do_reset(input logic k);
    key_1  = k;
    run_en = 1'b1;
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("rst_mode", int'(mode), 1);
    check("rst_led", int'(led), 1);
    check("rst_press", int'(key_press), 0);
    check("rst_tick", int'(step_tick), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // key, run, mode, led, press, tick: idle in M1 with a 2-cycle key glitch
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b1});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b10, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b1});

    @(negedge sys_clk);
    do_reset(1'b1);
    foreach (vq[i]) begin
      step(vq[i].key, vq[i].run);
      check($sformatf("vec%0d_mode", i), int'(s_mode), int'(vq[i].mode));
      check($sformatf("vec%0d_led", i), int'(s_led), int'(vq[i].led));
      check($sformatf("vec%0d_press", i), int'(s_press), int'(vq[i].press));
      check($sformatf("vec%0d_tick", i), int'(s_tick), int'(vq[i].tick));
    end

    // Held press landing on the last count of an M1 period
    do_reset(1'b1);
    first_press = -1; first_tick = -1; npress = 0;
    for (int i = 1; i <= 22; i++) begin
      step(1'b0, 1'b1);
      if (s_press) begin
        npress++;
        if (first_press < 0) begin
          first_press = i;
          check("press_blocks_tick", int'(s_tick), 0);
        end
      end
      if (first_press > 0 && i == first_press + 1) check("mode_after_press", int'(s_mode), 2);
      if (first_press > 0 && i == first_press + 2) check("m2_led_even", int'(s_led), 0);
      if (first_press > 0 && i == first_press + 8) check("m2_led_odd", int'(s_led), 3);
      if (first_press > 0 && i > first_press && s_tick && first_tick < 0) first_tick = i;
    end
    check("press_latency", first_press - 1, DEB + 3);
    check("press_count_held", npress, 1);
    check("m2_first_tick", first_tick - first_press, P2);

    // Reset asserted mid-debounce with the key still held afterwards
    repeat (10) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    do_reset(1'b0);
    first_press = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (s_press && first_press < 0) first_press = i;
    end
    check("held_rst_press_lat", first_press - 1, DEB + 3);
    check("held_rst_mode", int'(s_mode), 2);

    // Four presses wrap the mode; M4 counts in binary every P4 cycles
    do_reset(1'b1);
    for (int p = 0; p < 4; p++) begin
      repeat (10) step(1'b0, 1'b1);
      repeat (10) step(1'b1, 1'b1);
      check($sformatf("wrap_mode%0d", p), int'(s_mode), int'(wrap_exp[p]));
      if (p == 2) begin
        check("m4_led_start", int'(s_led), 1);
        prev_led = s_led; nchg = 0; last_chg = 0;
        for (int i = 1; i <= 45; i++) begin
          step(1'b1, 1'b1);
          if (s_led != prev_led && nchg < 4) begin
            check($sformatf("m4_led%0d", nchg), int'(s_led), int'(m4_seq[nchg]));
            if (nchg > 0) check($sformatf("m4_gap%0d", nchg), i - last_chg, P4);
            last_chg = i;
            nchg++;
          end
          prev_led = s_led;
        end
        check("m4_led_changes", nchg, 4);
      end
    end

    // run_en low for 15 cycles mid-period in M1 (phase 1, one count into the period)
    do_reset(1'b1);
    repeat (5) step(1'b1, 1'b1);
    nbad_frz = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0);
      if (s_tick || s_led != 2'b10) nbad_frz++;
    end
    check("freeze_activity", nbad_frz, 0);
    first_tick = -1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1);
      if (s_tick && first_tick < 0) first_tick = i;
      if (i == 5) check("resume_led", int'(s_led), 1);
    end
    check("resume_first_tick", first_tick, 3);

    // Randomized key hold lengths and run_en, checked against the model
    do_reset(1'b1);
    n = 0;
    while (n < 3000) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++) begin
        step(lvl[0], ($urandom_range(0, 7) != 0));
        n++;
      end
      if ($urandom_range(0, 199) == 0) do_reset(lvl[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flow_led_mode_ctrl.md
Name: flow_led_mode_ctrl

Overview:
Sequencer for the two-LED flow display. It debounces the user key (key_1) and steps a one-hot mode register through four modes on each press. It runs a per-mode step timer and drives the LED pattern phase for the active mode. The block sits between the board-level clock/reset/key pins and the LED outputs, replacing free-running flow logic with a key-selected, rate-controlled schedule.

Parameters:
CNT_W, 24, width of debounce and step counters
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a key level change (2..2^CNT_W-1)
PERIOD_1, 5_000_000, step period in cycles for MODE_1 (2..2^CNT_W)
PERIOD_2, 10_000_000, step period for MODE_2
PERIOD_3, 2_500_000, step period for MODE_3
PERIOD_4, 1_250_000, step period for MODE_4

Ports:
sys_clk  in  1  single system clock, all logic rising-edge
sys_rst_n  in  1  asynchronous active-low reset
key_1  in  1  raw push-button, active-low, asynchronous to sys_clk
run_en  in  1  1 = step timer runs; 0 = timer and phase frozen
mode  out  4  one-hot current mode: 4'b0001/0010/0100/1000 = MODE_1..MODE_4
key_press  out  1  one-cycle pulse on accepted press
step_tick  out  1  one-cycle pulse at end of each step period
led  out  2  LED drive, 1 = on

Behaviour:
- Reset (async assert, sync release): mode=4'b0001; key_press=0; step_tick=0; led=2'b01; phase=0; all counters=0; synchronizer flops and stable key level=1 (released).
- Synchronizer: key_1 passes through 2 flops (key_s) before any other use.
- Debounce: stable level `kst`. If key_s != kst, dbc increments; when dbc reaches DEBOUNCE_CYC-1 with key_s still != kst, kst<=key_s and dbc<=0. Any cycle with key_s == kst clears dbc. Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- key_press=1 for exactly the one cycle after kst goes 1->0. A release (0->1) produces no pulse. Holding the key yields a single pulse.
- Latency from key_1 falling (held low) to key_press: 2 + DEBOUNCE_CYC + 1 cycles.
- Mode FSM: states M1..M4 with mode encoding above. On the edge that samples key_press=1, advance M1->M2->M3->M4->M1 (wrap). The mode output changes the cycle after key_press.
- Step timer: tcnt counts 0..P-1, where P = PERIOD of the current mode.
  - When run_en=1 and tcnt==P-1: step_tick=1 for that one cycle, tcnt<=0, phase<=phase+1 (2-bit, wraps 3->0).
  - When run_en=0: tcnt and phase hold and step_tick=0.
- Mode change priority: on the edge that applies a mode change, tcnt<=0, phase<=0, and step_tick=0, even if a tick would otherwise fire.
  - The first tick in the new mode occurs P_new cycles after the change, provided run_en stays 1.
- LED decode is registered and updates one cycle after phase or mode changes:
  - M1: phase even 01, odd 10 (alternate).
  - M2: phase even 00, odd 11 (blink both).
  - M3: phase even 01, odd 00 (led[0] only).
  - M4: led = phase[1:0] (binary count 00,01,10,11).
- Reset mid-press: everything returns to reset values immediately. A key still held at release of reset is debounced to 0 but, because kst starts at 1, produces one key_press after DEBOUNCE_CYC+3 cycles. This is intended.
- run_en has no effect on debounce or mode stepping.

Test Plan:
Run with DEBOUNCE_CYC=4, PERIOD_1=4, PERIOD_2=6, PERIOD_3=8, PERIOD_4=10, CNT_W=8; clock 10 ns.
- Reset then idle, run_en=1 -> mode=0001; step_tick every 4 cycles; led toggles 01->10->01 each tick, one cycle after the tick.
- key_1 low 2 cycles, then high -> no key_press; mode stays 0001; dbc returns to 0.
- key_1 held low 20 cycles -> exactly one key_press, 7 cycles after the falling edge; mode=0010 next cycle; tcnt/phase cleared; first tick 6 cycles later; led 00/11 alternation.
- Four separate presses from M1 -> modes 0010, 0100, 1000, 0001 (wrap). In M4, led counts 00,01,10,11,00 at 10-cycle intervals.
- Press accepted on the same cycle tcnt==P-1 -> no step_tick that cycle; mode advances; tcnt=0.
- run_en=0 for 15 cycles mid-period in M1 -> no ticks and led frozen. After run_en=1, the remaining count completes before the next tick. Assert sys_rst_n low mid-debounce -> mode=0001, led=01, key_press=0 immediately (asynchronous).
